// File: rtl/alu_cmd_pkg.sv
// ============================================================================
//  Module      : alu_cmd_pkg
//  Description : Shared definitions for the ALU command sequencer: operation
//                encodings, default operand width, occupancy state type and
//                a helper that maps a buffer count onto an occupancy state.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_cmd_pkg;

  localparam int DEFAULT_WIDTH = 3;

  // Operation select encodings for cmd_op
  localparam logic [1:0] OP_INC  = 2'b00;  // A + 1
  localparam logic [1:0] OP_ADD  = 2'b01;  // A + B
  localparam logic [1:0] OP_SUB  = 2'b10;  // B - A
  localparam logic [1:0] OP_NEG1 = 2'b11;  // 1 - B

  // Result-buffer occupancy. The encoding is chosen so that bit 1 is
  // res_valid and bit 0 is cmd_ready, letting both handshake outputs come
  // straight from the state register.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'b01,
    OCC_PARTIAL = 2'b11,
    OCC_FULL    = 2'b10
  } occ_t;

  function automatic occ_t occ_from_count(input int cnt, input int depth);
    occ_t st;
    if (cnt == 0) begin
      st = OCC_EMPTY;
    end else if (cnt >= depth) begin
      st = OCC_FULL;
    end else begin
      st = OCC_PARTIAL;
    end
    return st;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_cmd_core.sv
// ============================================================================
//  Module      : alu_cmd_core
//  Description : Purely combinational arithmetic unit. All operations are
//                evaluated in WIDTH+1 bits; g is the low WIDTH bits and
//                carry is the top bit (carry / no-borrow).
//  Ports       : op    [1:0]       operation select (see alu_cmd_pkg)
//                a     [WIDTH-1:0] effective operand A
//                b     [WIDTH-1:0] operand B
//                g     [WIDTH-1:0] result
//                carry             bit WIDTH of the extended result
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_cmd_core
  import alu_cmd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g,
  output logic             carry
);

  localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

  logic [WIDTH:0] w_sum;

  // Subtractions use two's-complement add so that the top bit reads as
  // "no borrow" rather than a sign.
  always_comb begin
    w_sum = '0;
    case (op)
      OP_INC:  w_sum = {1'b0, a} + ONE;
      OP_ADD:  w_sum = {1'b0, a} + {1'b0, b};
      OP_SUB:  w_sum = {1'b0, b} + {1'b0, ~a} + ONE;
      OP_NEG1: w_sum = {1'b0, ~b} + ONE + ONE;
      default: w_sum = '0;
    endcase
  end

  assign g     = w_sum[WIDTH-1:0];
  assign carry = w_sum[WIDTH];

endmodule

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
//  Module      : alu_cmd_sequencer
//  Description : Accepts ALU commands over a valid/ready handshake, computes
//                the result in the acceptance cycle, and queues it in a
//                DEPTH-entry FIFO presented on a valid/ready result port.
//                Keeps an accumulator of the last accepted result (usable as
//                operand A via cmd_chain) and an 8-bit accepted-command count.
//  Ports       : clk, rst                 clock, async active-high reset
//                cmd_valid/cmd_ready      command handshake
//                cmd_op, cmd_a, cmd_b     operation and operands
//                cmd_chain                use acc in place of cmd_a
//                res_valid/res_ready      result handshake
//                res_g, res_carry, res_zero  result at FIFO head
//                acc                      last accepted result
//                op_count                 accepted-command counter (wraps)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_cmd_sequencer
  import alu_cmd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_chain,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_g,
  output logic             res_carry,
  output logic             res_zero,
  output logic [WIDTH-1:0] acc,
  output logic [7:0]       op_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  occ_t             r_state;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [WIDTH-1:0] r_acc;
  logic [7:0]       r_op_count;

  // Each entry holds {carry, g}; zero is re-derived at the head.
  logic [WIDTH:0]   r_mem [DEPTH];

  logic             w_accept;
  logic             w_xfer;
  logic [WIDTH-1:0] w_a_eff;
  logic [WIDTH-1:0] w_g;
  logic             w_carry;
  logic [CNT_W-1:0] w_count_next;
  logic [WIDTH:0]   w_head;

  // Handshake outputs are bits of the occupancy register, so neither has a
  // combinational path from res_ready or cmd_valid.
  assign cmd_ready = r_state[0];
  assign res_valid = r_state[1];

  assign w_accept = cmd_valid && cmd_ready;
  assign w_xfer   = res_valid && res_ready;
  assign w_a_eff  = cmd_chain ? r_acc : cmd_a;

  alu_cmd_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op    (cmd_op),
    .a     (w_a_eff),
    .b     (cmd_b),
    .g     (w_g),
    .carry (w_carry)
  );

  always_comb begin
    w_count_next = r_count;
    if (w_accept && !w_xfer) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (!w_accept && w_xfer) begin
      w_count_next = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= OCC_EMPTY;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_acc      <= '0;
      r_op_count <= '0;
    end else begin
      r_state <= occ_from_count(int'(w_count_next), DEPTH);
      r_count <= w_count_next;
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (w_accept) begin
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
        r_acc      <= w_g;
        r_op_count <= r_op_count + 8'd1;
      end
      if (w_xfer) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage is never observed while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= {w_carry, w_g};
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign res_g     = w_head[WIDTH-1:0];
  assign res_carry = w_head[WIDTH];
  assign res_zero  = (w_head[WIDTH-1:0] == '0);
  assign acc       = r_acc;
  assign op_count  = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
//  Module      : tb_alu_cmd_sequencer
//  Description : Self-checking bench for alu_cmd_sequencer: directed vector
//                table for the arithmetic plus hand-written sequences for
//                back-pressure, async reset and counter wrap.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_cmd_sequencer;
  import alu_cmd_pkg::*;

  localparam int W = 3;
  localparam int D = 2;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         cmd_chain;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_g;
  logic         res_carry;
  logic         res_zero;
  logic [W-1:0] acc;
  logic [7:0]   op_count;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_cnt  = 8'd0;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         chain;
    logic [W-1:0] g;
    logic         carry;
    logic         zero;
  } vec_t;

  vec_t vecs [12];

  alu_cmd_sequencer #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_chain (cmd_chain),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_g     (res_g),
    .res_carry (res_carry),
    .res_zero  (res_zero),
    .acc       (acc),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic chain);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_chain = chain;
    cmd_valid = 1'b1;
  endtask

  initial begin
    bit stalled;

    //              op       a     b     ch    g     c     z
    vecs[0]  = '{OP_ADD,  3'd3, 3'd2, 1'b0, 3'd5, 1'b0, 1'b0};
    vecs[1]  = '{OP_SUB,  3'd5, 3'd2, 1'b0, 3'd5, 1'b0, 1'b0};
    vecs[2]  = '{OP_SUB,  3'd2, 3'd5, 1'b0, 3'd3, 1'b1, 1'b0};
    vecs[3]  = '{OP_NEG1, 3'd0, 3'd1, 1'b0, 3'd0, 1'b1, 1'b1};
    vecs[4]  = '{OP_INC,  3'd7, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1};
    vecs[5]  = '{OP_ADD,  3'd5, 3'd6, 1'b1, 3'd6, 1'b0, 1'b0};  // acc=0 replaces a
    vecs[6]  = '{OP_INC,  3'd2, 3'd0, 1'b1, 3'd7, 1'b0, 1'b0};  // acc=6 replaces a
    vecs[7]  = '{OP_NEG1, 3'd4, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0};
    vecs[8]  = '{OP_NEG1, 3'd0, 3'd2, 1'b0, 3'd7, 1'b0, 1'b0};
    vecs[9]  = '{OP_ADD,  3'd7, 3'd7, 1'b0, 3'd6, 1'b1, 1'b0};
    vecs[10] = '{OP_SUB,  3'd3, 3'd3, 1'b0, 3'd0, 1'b1, 1'b1};
    vecs[11] = '{OP_INC,  3'd3, 3'd5, 1'b0, 3'd4, 1'b0, 1'b0};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_chain = 1'b0;
    res_ready = 1'b0;
    #2;
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_acc",       32'(acc),       32'd0);
    check("reset_op_count",  32'(op_count),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single commands with an always-ready consumer
    res_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].chain);
      step();
      cmd_valid = 1'b0;
      exp_cnt   = exp_cnt + 8'd1;
      check($sformatf("vec%0d_res_valid", i), 32'(res_valid), 32'd1);
      check($sformatf("vec%0d_res_g", i),     32'(res_g),     32'(vecs[i].g));
      check($sformatf("vec%0d_carry", i),     32'(res_carry), 32'(vecs[i].carry));
      check($sformatf("vec%0d_zero", i),      32'(res_zero),  32'(vecs[i].zero));
      check($sformatf("vec%0d_acc", i),       32'(acc),       32'(vecs[i].g));
      check($sformatf("vec%0d_op_count", i),  32'(op_count),  32'(exp_cnt));
      step();
      check($sformatf("vec%0d_drained", i),   32'(res_valid), 32'd0);
    end

    // Back-pressure: fill the buffer, block a third command, then drain
    res_ready = 1'b0;
    drive(OP_ADD, 3'd1, 3'd1, 1'b0);            // g = 2
    step();
    exp_cnt = exp_cnt + 8'd1;
    check("bp_ready_after_1", 32'(cmd_ready), 32'd1);
    drive(OP_INC, 3'd4, 3'd0, 1'b0);            // g = 5
    step();
    exp_cnt = exp_cnt + 8'd1;
    check("bp_ready_full",    32'(cmd_ready), 32'd0);
    check("bp_head_first",    32'(res_g),     32'd2);
    drive(OP_NEG1, 3'd0, 3'd3, 1'b0);           // g = 6, carry 0
    step();
    check("bp_blocked_count", 32'(op_count),  32'(exp_cnt));
    check("bp_head_stable",   32'(res_g),     32'd2);
    check("bp_still_full",    32'(cmd_ready), 32'd0);
    res_ready = 1'b1;
    step();                                     // first transfer, accept blocked
    check("bp_no_accept_full", 32'(op_count), 32'(exp_cnt));
    check("bp_head_second",   32'(res_g),     32'd5);
    check("bp_ready_reopen",  32'(cmd_ready), 32'd1);
    step();                                     // accept + transfer together
    exp_cnt = exp_cnt + 8'd1;
    cmd_valid = 1'b0;
    check("bp_third_accept",  32'(op_count),  32'(exp_cnt));
    check("bp_head_third",    32'(res_g),     32'd6);
    check("bp_third_carry",   32'(res_carry), 32'd0);
    check("bp_count_held",    32'(res_valid), 32'd1);
    check("bp_count_held_rdy", 32'(cmd_ready), 32'd1);
    check("bp_acc",           32'(acc),       32'd6);
    step();
    check("bp_empty",         32'(res_valid), 32'd0);

    // Asynchronous reset with two buffered results
    res_ready = 1'b0;
    drive(OP_ADD, 3'd1, 3'd2, 1'b0);
    step();
    drive(OP_ADD, 3'd2, 3'd2, 1'b0);
    step();
    cmd_valid = 1'b0;
    check("ar_full_before", 32'(cmd_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("ar_res_valid",   32'(res_valid), 32'd0);
    check("ar_acc",         32'(acc),       32'd0);
    check("ar_op_count",    32'(op_count),  32'd0);
    check("ar_cmd_ready",   32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst       = 1'b0;
    exp_cnt   = 8'd0;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("ar_no_stale%0d", i), 32'(res_valid), 32'd0);
    end

    // op_count wrap with continuous accept/transfer at count 1
    drive(OP_ADD, 3'd1, 3'd1, 1'b0);
    stalled = 1'b0;
    for (int i = 0; i < 255; i++) begin
      step();
      if (!cmd_ready) stalled = 1'b1;
    end
    check("wrap_never_stalled", 32'(stalled), 32'd0);
    check("wrap_255",           32'(op_count), 32'd255);
    step();
    check("wrap_0",             32'(op_count), 32'd0);
    check("wrap_res_valid",     32'(res_valid), 32'd1);
    check("wrap_cmd_ready",     32'(cmd_ready), 32'd1);
    check("wrap_acc",           32'(acc),       32'd2);
    cmd_valid = 1'b0;
    step();
    check("wrap_drained",       32'(res_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
